board_renderer: RTL and testbench

- Upstream pixel source for vgac; drives its d_in_BGR.
- Converts vgac's X_Addr/Y_Addr/read into 12-bit BGR (bbbb_gggg_rrrr) pixels showing the 4x4 2048 board.
- Game logic writes cell exponents into a shadow board, then requests a commit. The displayed board swaps only at the vs falling edge, so no frame ever shows a torn board.

---
 rtl/board_pkg.sv | 28 ++
 rtl/board_renderer_if.sv | 28 ++
 rtl/tile_locator.sv | 81 ++++++++
 rtl/board_renderer.sv | 87 ++++++++
 tb/tb_board_renderer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the 2048 board renderer: pixel format, tile palette,
// default board geometry and the commit-state encoding.
package board_pkg;

    localparam int unsigned BGR_W = 12;
    typedef logic [BGR_W-1:0] bgr_t;

    localparam int unsigned X0_DEF     = 120;
    localparam int unsigned Y0_DEF     = 40;
    localparam int unsigned PITCH_DEF  = 100;
    localparam int unsigned BORDER_DEF = 4;

    localparam bgr_t BG       = 12'hDEF;
    localparam bgr_t BORDER_C = 12'h9AB;

    // Index is the cell exponent; 12 and above share one dark colour.
    localparam bgr_t PALETTE [16] = '{
        12'hBCC, 12'hDEE, 12'hCDE, 12'h7BF, 12'h69F, 12'h57F, 12'h35F, 12'h7DE,
        12'h6CE, 12'h5CE, 12'h3CE, 12'h2CE, 12'h333, 12'h333, 12'h333, 12'h333
    };

    typedef enum logic {StIdle, StPending} commit_st_e;

    function automatic bgr_t cell_color(input logic [3:0] exp_val);
        return PALETTE[exp_val];
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Bus between the renderer, the vgac scan side and the game-logic writer.
// master = the environment driving scan/cell traffic, slave = the renderer.
interface board_renderer_if;
    import board_pkg::*;

    logic       read;
    logic [9:0] x_addr;
    logic [8:0] y_addr;
    logic       vs;
    logic       cell_wr_en;
    logic [3:0] cell_idx;
    logic [3:0] cell_val;
    logic       commit;
    logic       pending;
    logic       swap_done;
    bgr_t       d_out_BGR;

    modport master (
        output read, x_addr, y_addr, vs, cell_wr_en, cell_idx, cell_val, commit,
        input  pending, swap_done, d_out_BGR
    );

    modport slave (
        input  read, x_addr, y_addr, vs, cell_wr_en, cell_idx, cell_val, commit,
        output pending, swap_done, d_out_BGR
    );

endinterface

// File: rtl/tile_locator.sv
// Maps a vgac scan address onto the 4x4 board (tile row/col, border hit) using
// compares against constant multiples of the pitch, then registers the result.
module tile_locator
    import board_pkg::*;
#(
    parameter int unsigned X0     = X0_DEF,
    parameter int unsigned Y0     = Y0_DEF,
    parameter int unsigned PITCH  = PITCH_DEF,
    parameter int unsigned BORDER = BORDER_DEF
) (
    input  logic       vga_clk,
    input  logic       clrn,
    input  logic       i_read,
    input  logic [9:0] i_x_addr,
    input  logic [8:0] i_y_addr,
    output logic       o_read_d1,
    output logic       o_in_board,
    output logic [1:0] o_col,
    output logic [1:0] o_row,
    output logic       o_on_border
);

    localparam logic [9:0] C_X0  = 10'(X0);
    localparam logic [9:0] C_Y0  = 10'(Y0);
    localparam logic [9:0] C_XE  = 10'(X0 + 4 * PITCH);
    localparam logic [9:0] C_YE  = 10'(Y0 + 4 * PITCH);
    localparam logic [9:0] C_P1  = 10'(PITCH);
    localparam logic [9:0] C_P2  = 10'(2 * PITCH);
    localparam logic [9:0] C_P3  = 10'(3 * PITCH);
    localparam logic [9:0] C_B   = 10'(BORDER);
    localparam logic [9:0] C_PB  = 10'(PITCH - BORDER);

    function automatic logic [1:0] tile_of(input logic [9:0] d);
        if (d >= C_P3)      return 2'd3;
        else if (d >= C_P2) return 2'd2;
        else if (d >= C_P1) return 2'd1;
        else                return 2'd0;
    endfunction

    function automatic logic [9:0] tile_base(input logic [1:0] t);
        case (t)
            2'd0:    return 10'd0;
            2'd1:    return C_P1;
            2'd2:    return C_P2;
            default: return C_P3;
        endcase
    endfunction

    logic [9:0] w_yt, w_dx, w_dy, w_ox, w_oy;
    logic [1:0] w_col, w_row;
    logic       w_in_board, w_on_border;

    // y_addr counts up from the bottom; out-of-range values wrap high and miss the board.
    assign w_yt  = 10'd479 - {1'b0, i_y_addr};
    assign w_dx  = i_x_addr - C_X0;
    assign w_dy  = w_yt - C_Y0;
    assign w_col = tile_of(w_dx);
    assign w_row = tile_of(w_dy);
    assign w_ox  = w_dx - tile_base(w_col);
    assign w_oy  = w_dy - tile_base(w_row);

    assign w_in_board  = (i_x_addr >= C_X0) & (i_x_addr < C_XE) & (w_yt >= C_Y0) & (w_yt < C_YE);
    assign w_on_border = (w_ox < C_B) | (w_ox >= C_PB) | (w_oy < C_B) | (w_oy >= C_PB);

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            o_read_d1   <= 1'b0;
            o_in_board  <= 1'b0;
            o_col       <= 2'd0;
            o_row       <= 2'd0;
            o_on_border <= 1'b0;
        end else begin
            o_read_d1   <= i_read;
            o_in_board  <= w_in_board;
            o_col       <= w_col;
            o_row       <= w_row;
            o_on_border <= w_on_border;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Pixel source for vgac showing the 2048 board. Game logic fills a shadow board and
// commits; the displayed board swaps whole at the next vs falling edge.
module board_renderer
    import board_pkg::*;
#(
    parameter int unsigned X0     = X0_DEF,
    parameter int unsigned Y0     = Y0_DEF,
    parameter int unsigned PITCH  = PITCH_DEF,
    parameter int unsigned BORDER = BORDER_DEF
) (
    input  logic              vga_clk,
    input  logic              clrn,
    board_renderer_if.slave   bus
);

    logic [15:0][3:0] r_shadow;
    logic [15:0][3:0] r_front;
    commit_st_e       r_state;
    logic             r_vs_d;
    logic             r_swap_done;
    bgr_t             r_pix;

    logic       w_read_d1, w_in_board, w_on_border;
    logic [1:0] w_col, w_row;
    logic       w_fall, w_swap;

    tile_locator #(
        .X0     (X0),
        .Y0     (Y0),
        .PITCH  (PITCH),
        .BORDER (BORDER)
    ) u_tile_locator (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .i_read      (bus.read),
        .i_x_addr    (bus.x_addr),
        .i_y_addr    (bus.y_addr),
        .o_read_d1   (w_read_d1),
        .o_in_board  (w_in_board),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_on_border (w_on_border)
    );

    assign w_fall = r_vs_d & ~bus.vs;
    assign w_swap = w_fall & (r_state == StPending);

    // Swap copies the shadow as it stood before any same-cycle write.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_shadow    <= '0;
            r_front     <= '0;
            r_state     <= StIdle;
            r_vs_d      <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_vs_d      <= bus.vs;
            r_swap_done <= w_swap;
            if (bus.cell_wr_en) r_shadow[bus.cell_idx] <= bus.cell_val;
            if (w_swap) r_front <= r_shadow;
            unique case (r_state)
                StIdle:    if (bus.commit) r_state <= StPending;
                StPending: if (w_fall && !bus.commit) r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_pix <= '0;
        end else if (!w_read_d1) begin
            r_pix <= '0;
        end else if (!w_in_board) begin
            r_pix <= BG;
        end else if (w_on_border) begin
            r_pix <= BORDER_C;
        end else begin
            r_pix <= cell_color(r_front[{w_row, w_col}]);
        end
    end

    assign bus.pending   = (r_state == StPending);
    assign bus.swap_done = r_swap_done;
    assign bus.d_out_BGR = r_pix;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboarded bench for board_renderer: expected pixels are queued when an address
// is driven and checked when they are due two clocks later.
module tb_board_renderer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    board_renderer_if bus ();

    board_renderer dut (
        .vga_clk (clk),
        .clrn    (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [11:0] exp;
        int x;
        int y;
        bit rd;
    } exp_t;

    exp_t q[$];

    logic [3:0] m_shadow [16];
    logic [3:0] m_front [16];
    bit m_pending;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] pal(input logic [3:0] e);
        case (e)
            4'd0:  return 12'hBCC;
            4'd1:  return 12'hDEE;
            4'd2:  return 12'hCDE;
            4'd3:  return 12'h7BF;
            4'd4:  return 12'h69F;
            4'd5:  return 12'h57F;
            4'd6:  return 12'h35F;
            4'd7:  return 12'h7DE;
            4'd8:  return 12'h6CE;
            4'd9:  return 12'h5CE;
            4'd10: return 12'h3CE;
            4'd11: return 12'h2CE;
            default: return 12'h333;
        endcase
    endfunction

    function automatic logic [11:0] model_pix(input int x, input int y, input bit rd);
        int yt, dx, dy, ox, oy;
        yt = 479 - y;
        if (!rd) return 12'h000;
        if (x < 120 || x >= 520 || yt < 40 || yt >= 440) return 12'hDEF;
        dx = x - 120;
        dy = yt - 40;
        ox = dx % 100;
        oy = dy % 100;
        if (ox < 4 || ox >= 96 || oy < 4 || oy >= 96) return 12'h9AB;
        return pal(m_front[(dy / 100) * 4 + dx / 100]);
    endfunction

    // Output checker: pops each expectation on the cycle it is due.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk($sformatf("pix(%0d,%0d,rd=%0d)", e.x, e.y, e.rd), bus.d_out_BGR, e.exp);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = 4'd0;
            m_front[i]  = 4'd0;
        end
        m_pending = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input bit rd);
        exp_t e;
        bus.read   = rd;
        bus.x_addr = 10'(x);
        bus.y_addr = 9'(y);
        e.due = cyc + 2;
        e.exp = model_pix(x, y, rd);
        e.x = x;
        e.y = y;
        e.rd = rd;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [3:0] val);
        bus.cell_wr_en = 1'b1;
        bus.cell_idx = idx;
        bus.cell_val = val;
        m_shadow[idx] = val;
        @(negedge clk);
        bus.cell_wr_en = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        m_pending = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        chk("pending_after_commit", bus.pending, m_pending);
    endtask

    // One-cycle vs low pulse, optionally with a commit and/or a write in the fall cycle.
    task automatic frame_fall(input bit c, input bit w, input logic [3:0] idx,
                              input logic [3:0] val);
        bit exp_swap;
        drain();
        bus.vs = 1'b0;
        bus.commit = c;
        bus.cell_wr_en = w;
        bus.cell_idx = idx;
        bus.cell_val = val;
        exp_swap = m_pending;
        if (m_pending) begin
            for (int i = 0; i < 16; i++) m_front[i] = m_shadow[i];
            m_pending = c;
        end else if (c) begin
            m_pending = 1'b1;
        end
        if (w) m_shadow[idx] = val;
        @(negedge clk);
        bus.vs = 1'b1;
        bus.commit = 1'b0;
        bus.cell_wr_en = 1'b0;
        chk("swap_done", bus.swap_done, exp_swap);
        chk("pending_after_fall", bus.pending, m_pending);
        @(negedge clk);
        chk("swap_done_pulse_end", bus.swap_done, 1'b0);
    endtask

    initial begin
        bus.read = 1'b0;
        bus.x_addr = '0;
        bus.y_addr = '0;
        bus.vs = 1'b1;
        bus.cell_wr_en = 1'b0;
        bus.cell_idx = '0;
        bus.cell_val = '0;
        bus.commit = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_pix", bus.d_out_BGR, 12'h000);
        chk("rst_pending", bus.pending, 1'b0);
        chk("rst_swap_done", bus.swap_done, 1'b0);
        rst_n = 1'b1;

        // Empty board after reset
        pix(170, 389, 1'b1);
        pix(470, 89, 1'b1);
        drain();

        // Write without commit: no swap on vs fall
        wr(4'd0, 4'd11);
        frame_fall(1'b0, 1'b0, 4'd0, 4'd0);
        pix(170, 389, 1'b1);
        drain();
        do_commit();
        frame_fall(1'b0, 1'b0, 4'd0, 4'd0);
        pix(170, 389, 1'b1);

        // Border, background, blanking and edges
        pix(121, 389, 1'b1);
        pix(50, 389, 1'b1);
        pix(300, 200, 1'b0);
        pix(170, 389, 1'b0);
        pix(219, 389, 1'b1);
        pix(224, 389, 1'b1);
        pix(519, 389, 1'b1);
        pix(520, 389, 1'b1);
        pix(170, 40, 1'b1);
        pix(170, 39, 1'b1);
        pix(170, 439, 1'b1);
        pix(170, 440, 1'b1);
        drain();

        // Commit mid-frame; front unchanged until vs falls
        wr(4'd15, 4'd1);
        do_commit();
        pix(470, 89, 1'b1);
        drain();
        chk("pending_held", bus.pending, 1'b1);
        frame_fall(1'b0, 1'b0, 4'd0, 4'd0);
        pix(470, 89, 1'b1);
        drain();

        // Commit in the swap cycle re-arms; write in that cycle waits for the next swap
        wr(4'd3, 4'd5);
        do_commit();
        frame_fall(1'b1, 1'b1, 4'd5, 4'd7);
        pix(470, 389, 1'b1);
        pix(270, 289, 1'b1);
        drain();
        frame_fall(1'b0, 1'b0, 4'd0, 4'd0);
        pix(270, 289, 1'b1);
        drain();

        // Random boards and scan addresses
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) wr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            do_commit();
            frame_fall(1'b0, 1'b0, 4'd0, 4'd0);
            for (int k = 0; k < 30; k++)
                pix($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7) != 0);
            drain();
        end

        // Async reset mid-line, away from any clock edge
        wr(4'd6, 4'd9);
        do_commit();
        bus.read = 1'b1;
        bus.x_addr = 10'd170;
        bus.y_addr = 9'd389;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pix", bus.d_out_BGR, 12'h000);
        chk("async_rst_pending", bus.pending, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pix(170, 389, 1'b1);
        pix(370, 289, 1'b1);
        drain();
        frame_fall(1'b0, 1'b0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
